uart_rx_edge_sampler: RTL and testbench

Receive-side timing and sampling stage of the UART RX path. It counts oversampling edges and bit periods while the RX controller holds `enable`, and majority-votes three samples around the bit centre. It drives `edge_cnt`, `bit_cnt` and `sampled_bit` into the RX controller and into the start, parity and stop checkers and the deserializer. Oversampling is fixed at 2^EDGE_W clocks per bit, which is 8 at the default width.

---
 rtl/uart_rx_edge_sampler_pkg.sv | 18 +
 rtl/uart_rx_edge_sampler_if.sv | 32 +++
 rtl/uart_rx_sync2.sv | 26 ++
 rtl/uart_rx_edge_sampler.sv | 100 ++++++++++
 tb/tb_uart_rx_edge_sampler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_edge_sampler_pkg.sv
// Shared constants and helpers for the UART RX path: counter widths, frame
// bit indices and the 3-input majority vote.
package uart_rx_pkg;

  localparam int EDGE_W_DEF    = 3;
  localparam int BIT_W_DEF     = 4;
  localparam int SMP_MID_DEF   = 4;
  localparam int LAST_EDGE     = (1 << EDGE_W_DEF) - 1;

  localparam int BIT_START     = 0;
  localparam int BIT_DATA_LAST = 8;
  localparam int BIT_PARITY    = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_sampler_if.sv
// Bus between the RX controller (master) and the edge sampler (slave).
// rx_line is the line the sampler actually looks at, exported so the
// controller's falling-edge detect sees the same (possibly synchronized) signal.
interface uart_rx_edge_sampler_if
  import uart_rx_pkg::*;
#(
  parameter int EDGE_W = EDGE_W_DEF,
  parameter int BIT_W  = BIT_W_DEF
);

  // sample_strb is a one-cycle valid pulse with no ready: the consumer must
  // take sampled_bit in that cycle or later within the same bit period.
  logic              rx_in;
  logic              enable;
  logic              dat_samp_en;
  logic [EDGE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sampled_bit;
  logic              sample_strb;
  logic              rx_line;

  modport master (
    output rx_in, enable, dat_samp_en,
    input  edge_cnt, bit_cnt, sampled_bit, sample_strb, rx_line
  );

  modport slave (
    input  rx_in, enable, dat_samp_en,
    output edge_cnt, bit_cnt, sampled_bit, sample_strb, rx_line
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module uart_rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART RX edge/bit counter and 3-sample majority sampler around the bit centre.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx_in.
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int EDGE_W  = EDGE_W_DEF,
  parameter int BIT_W   = BIT_W_DEF,
  parameter int SMP_MID = SMP_MID_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_rx_edge_sampler_if.slave   bus
);

  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'((1 << EDGE_W) - 1);
  localparam logic [EDGE_W-1:0] EDGE_S0   = EDGE_W'(SMP_MID - 1);
  localparam logic [EDGE_W-1:0] EDGE_S1   = EDGE_W'(SMP_MID);
  localparam logic [EDGE_W-1:0] EDGE_VOTE = EDGE_W'(SMP_MID + 1);
  localparam logic [BIT_W-1:0]  BIT_SAT   = BIT_W'((1 << BIT_W) - 1);
  localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(BIT_START);

  // The frame needs start + data + parity + stop indices, and the vote must
  // finish with room for the strobe before the last edge.
  if ((1 << BIT_W) - 1 < BIT_PARITY + 1 || BIT_DATA_LAST + 1 != BIT_PARITY ||
      SMP_MID < 1 || SMP_MID > (1 << EDGE_W) - 4) begin : g_bad_cfg
    $error("uart_rx_edge_sampler: illegal BIT_W/EDGE_W/SMP_MID");
  end

  logic w_line;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.rx_in),
    .o_q (w_line)
  );
`else
  assign w_line = bus.rx_in;
`endif

  logic [EDGE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_s0;
  logic              r_s1;
  logic              r_sampled_bit;
  logic              r_sample_strb;

  logic w_last_edge;
  logic w_at_s0;
  logic w_at_s1;
  logic w_at_vote;

  assign w_last_edge = (r_edge_cnt == EDGE_LAST);
  assign w_at_s0     = bus.dat_samp_en && (r_edge_cnt == EDGE_S0);
  assign w_at_s1     = bus.dat_samp_en && (r_edge_cnt == EDGE_S1);
  assign w_at_vote   = bus.dat_samp_en && (r_edge_cnt == EDGE_VOTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_cnt    <= '0;
      r_bit_cnt     <= BIT_FIRST;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_sampled_bit <= 1'b1;
      r_sample_strb <= 1'b0;
    end else begin
      r_sample_strb <= 1'b0;
      if (!bus.enable) begin
        // Abort or idle: counters clear and any half-taken samples are dropped.
        r_edge_cnt <= '0;
        r_bit_cnt  <= BIT_FIRST;
        r_s0       <= 1'b1;
        r_s1       <= 1'b1;
      end else begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
        if (w_last_edge && (r_bit_cnt != BIT_SAT)) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_at_s0) begin
          r_s0 <= w_line;
        end
        if (w_at_s1) begin
          r_s1 <= w_line;
        end
        if (w_at_vote) begin
          r_sampled_bit <= maj3(r_s0, r_s1, w_line);
          r_sample_strb <= 1'b1;
        end
      end
    end
  end

  assign bus.edge_cnt    = r_edge_cnt;
  assign bus.bit_cnt     = r_bit_cnt;
  assign bus.sampled_bit = r_sampled_bit;
  assign bus.sample_strb = r_sample_strb;
  assign bus.rx_line     = w_line;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed bench for uart_rx_edge_sampler: cycle-accurate counter model plus
// an expected-bit queue popped on every sample strobe.
module tb_uart_rx_edge_sampler;
  import uart_rx_pkg::*;

`ifdef UART_RX_SYNC_EN
  localparam int LEAD = 2;
`else
  localparam int LEAD = 0;
`endif
  localparam int SMP_MID   = 4;
  localparam int BIT_MAX   = 15;
  localparam int STRB_EDGE = SMP_MID + 2;

  // clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_edge_sampler_if bus ();

  uart_rx_edge_sampler #(
    .EDGE_W  (3),
    .BIT_W   (4),
    .SMP_MID (SMP_MID)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard state
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [0:0] exp_q[$];
  int         cyc = 0;
  int         n_strb = 0;
  int         first_strb_cyc = -1;
  bit         mon_en = 1'b0;
  int         m_edge = 0;
  int         m_bit  = 0;
  logic       pat[0:255];
  logic       fb[0:9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the counter model, compare the counters.
  task automatic cycle(input logic rx, input logic en, input logic samp);
    bus.rx_in       = rx;
    bus.enable      = en;
    bus.dat_samp_en = samp;
    @(posedge clk);
    #1;
    cyc++;
    if (!en) begin
      m_edge = 0;
      m_bit  = 0;
    end else if (m_edge == LAST_EDGE) begin
      m_edge = 0;
      if (m_bit != BIT_MAX) m_bit++;
    end else begin
      m_edge++;
    end
    chk("edge_cnt", bus.edge_cnt, m_edge);
    chk("bit_cnt", bus.bit_cnt, m_bit);
  endtask

  // pat[e] is the line value the sampler should see at counter edge e; the
  // raw pin leads enable by LEAD clocks to cover the synchronizer.
  task automatic run_pattern(input int n, input logic samp);
    for (int c = 0; c < n + LEAD; c++) begin
      cycle((c < n) ? pat[c] : 1'b1, (c >= LEAD), samp);
    end
  endtask

  task automatic one_bit(input logic [7:0] line_edges, input logic expv);
    for (int e = 0; e < 8; e++) pat[e] = line_edges[e];
    exp_q.push_back(expv);
    run_pattern(8, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("q_empty_bit", exp_q.size(), 0);
  endtask

  // strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en && bus.sample_strb === 1'b1) begin
      n_strb++;
      if (first_strb_cyc < 0) first_strb_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("strb_unexpected", bus.sample_strb, 0);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        chk("sampled_bit", bus.sampled_bit, e);
      end
      chk("strb_edge", bus.edge_cnt, STRB_EDGE);
    end
  end

  initial begin
    int         k;
    int         n0;
    logic [7:0] d;

    // reset with enable high
    rst             = 1'b1;
    bus.rx_in       = 1'b0;
    bus.enable      = 1'b1;
    bus.dat_samp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_edge_cnt", bus.edge_cnt, 0);
    chk("rst_bit_cnt", bus.bit_cnt, 0);
    chk("rst_sampled_bit", bus.sampled_bit, 1);
    chk("rst_sample_strb", bus.sample_strb, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // clean frame 8'hA5, no parity
    d     = 8'hA5;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
    fb[9] = 1'b1;
    for (int b = 0; b < 10; b++) begin
      exp_q.push_back(fb[b]);
      for (int e = 0; e < 8; e++) pat[8 * b + e] = fb[b];
    end
    k = cyc;
    n_strb = 0;
    first_strb_cyc = -1;
    run_pattern(80, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("frame_strb_cnt", n_strb, 10);
    chk("frame_strb_lat", first_strb_cyc - k, STRB_EDGE + LEAD);
    chk("frame_q_empty", exp_q.size(), 0);

    // glitch rejection and two-of-three votes
    one_bit(8'b1110_1111, 1'b1);
    one_bit(8'b1101_0111, 1'b0);
    one_bit(8'b1110_1111, 1'b1);
    one_bit(8'b1100_1111, 1'b0);
    one_bit(8'b1111_0111, 1'b1);

    // sampling window closed: no strobe, sampled_bit holds
    for (int e = 0; e < 8; e++) pat[e] = 1'b0;
    n0 = n_strb;
    run_pattern(8, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("nosamp_strb", n_strb - n0, 0);
    chk("nosamp_hold", bus.sampled_bit, 1);

    // abort at bit 3 edge 2, then recover without reset
    for (int b = 0; b < 3; b++) exp_q.push_back(1'b1);
    for (int c = 0; c < 26; c++) cycle(1'b1, 1'b1, 1'b1);
    chk("abort_pre_bit", bus.bit_cnt, 3);
    chk("abort_pre_edge", bus.edge_cnt, 2);
    n0 = n_strb;
    cycle(1'b1, 1'b0, 1'b1);
    repeat (8) cycle(1'b1, 1'b0, 1'b1);
    chk("abort_no_strb", n_strb - n0, 0);
    chk("abort_q_empty", exp_q.size(), 0);
    one_bit(8'b0000_0000, 1'b0);

    // bit counter saturation
    for (int c = 0; c < 160; c++) cycle(1'b1, 1'b1, 1'b0);
    chk("sat_bit_cnt", bus.bit_cnt, BIT_MAX);
    cycle(1'b1, 1'b0, 1'b0);
    chk("sat_clear", bus.bit_cnt, 0);

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    chk("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
